// File: rtl/shift_exec_stage.sv
// Execute-stage ARM barrel shifter: resolves the operand, applies the decoded shift/rotate
// and registers shifter_operand/shifter_carry behind a valid/ready handshake with a skid entry.
module shift_exec_stage #(
  parameter int unsigned    DATAW         = 32,
  parameter int unsigned    AMTW          = 8,
  parameter int unsigned    OPW           = 3,
  parameter logic [OPW-1:0] OP_DATA_SHIFT = OPW'(0),
  parameter logic [OPW-1:0] OP_DATA_ROR   = OPW'(1),
  parameter logic [OPW-1:0] OP_LDSTR_IMM  = OPW'(2),
  parameter logic [OPW-1:0] OP_LDSTR_REG  = OPW'(3)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   optype,
  input  logic [DATAW-1:0] rm_val,
  input  logic [DATAW-1:0] bypass_rm,
  input  logic             should_bypass_rm,
  input  logic [1:0]       shiftcode,
  input  logic [AMTW-1:0]  shiftby,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] shifter_operand,
  output logic             shifter_carry
);

  typedef enum logic [1:0] {
    SH_LSL = 2'd0,
    SH_LSR = 2'd1,
    SH_ASR = 2'd2,
    SH_ROR = 2'd3
  } shift_e;

  logic [DATAW-1:0] op;
  logic [4:0]       n;
  logic [4:0]       rot;
  logic [DATAW-1:0] res;
  logic             cout;
  shift_e           code;

  logic             out_valid_q, out_valid_d;
  logic [DATAW-1:0] out_op_q, out_op_d;
  logic             out_c_q, out_c_d;
  logic             skid_valid_q, skid_valid_d;
  logic [DATAW-1:0] skid_op_q, skid_op_d;
  logic             skid_c_q, skid_c_d;
  logic             accept;

  logic unused_amt;
  assign unused_amt = ^shiftby[AMTW-1:5];

  // Shifter datapath; an amount field of zero encodes the special ARM forms (x32 / RRX)
  always_comb begin
    op   = should_bypass_rm ? bypass_rm : rm_val;
    n    = shiftby[4:0];
    rot  = {shiftby[3:0], 1'b0};
    code = shift_e'(shiftcode);
    res  = op;
    cout = carry_in;
    if (optype == OP_DATA_ROR) begin
      if (rot != 5'd0) begin
        res  = (op >> rot) | (op << (DATAW - int'(rot)));
        cout = res[DATAW-1];
      end
    end else if ((optype == OP_DATA_SHIFT) || (optype == OP_LDSTR_REG)) begin
      case (code)
        SH_LSL: begin
          if (n != 5'd0) begin
            res  = op << n;
            cout = op[5'(DATAW - int'(n))];
          end
        end
        SH_LSR: begin
          if (n == 5'd0) begin
            res  = '0;
            cout = op[DATAW-1];
          end else begin
            res  = op >> n;
            cout = op[n - 5'd1];
          end
        end
        SH_ASR: begin
          if (n == 5'd0) begin
            res  = {DATAW{op[DATAW-1]}};
            cout = op[DATAW-1];
          end else begin
            res  = $signed(op) >>> n;
            cout = op[n - 5'd1];
          end
        end
        SH_ROR: begin
          if (n == 5'd0) begin
            res  = {carry_in, op[DATAW-1:1]};
            cout = op[0];
          end else begin
            res  = (op >> n) | (op << (DATAW - int'(n)));
            cout = op[n - 5'd1];
          end
        end
        default: begin
          res  = op;
          cout = carry_in;
        end
      endcase
    end
  end

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;

  // Skid can only be full while in_ready is low, so refilling the output from the skid
  // and accepting new input are mutually exclusive.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_op_d     = out_op_q;
    out_c_d      = out_c_q;
    skid_valid_d = skid_valid_q;
    skid_op_d    = skid_op_q;
    skid_c_d     = skid_c_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_op_d     = skid_op_q;
        out_c_d      = skid_c_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_op_d    = res;
        out_c_d     = cout;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_op_d    = res;
      skid_c_d     = cout;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_op_q     <= '0;
      out_c_q      <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_op_q    <= '0;
      skid_c_q     <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_op_q     <= out_op_d;
      out_c_q      <= out_c_d;
      skid_valid_q <= skid_valid_d;
      skid_op_q    <= skid_op_d;
      skid_c_q     <= skid_c_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign shifter_operand = out_op_q;
  assign shifter_carry   = out_c_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Bench for shift_exec_stage: vector table through a scoreboard, plus stall, flush and reset sequences.
module tb_shift_exec_stage;

  localparam logic [2:0] OP_SHIFT = 3'd0;
  localparam logic [2:0] OP_ROR   = 3'd1;
  localparam logic [2:0] OP_LDIMM = 3'd2;
  localparam logic [2:0] OP_LDREG = 3'd3;
  localparam logic [2:0] OP_OTHER = 3'd5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  optype = '0;
  logic [31:0] rm_val = '0;
  logic [31:0] bypass_rm = '0;
  logic        should_bypass_rm = 1'b0;
  logic [1:0]  shiftcode = '0;
  logic [7:0]  shiftby = '0;
  logic        carry_in = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] shifter_operand;
  logic        shifter_carry;

  shift_exec_stage #(
    .DATAW(32), .AMTW(8), .OPW(3),
    .OP_DATA_SHIFT(OP_SHIFT), .OP_DATA_ROR(OP_ROR),
    .OP_LDSTR_IMM(OP_LDIMM), .OP_LDSTR_REG(OP_LDREG)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .optype(optype), .rm_val(rm_val), .bypass_rm(bypass_rm),
    .should_bypass_rm(should_bypass_rm), .shiftcode(shiftcode),
    .shiftby(shiftby), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .shifter_operand(shifter_operand), .shifter_carry(shifter_carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rm;
    logic [31:0] byp;
    logic        sel;
    logic [1:0]  code;
    logic [7:0]  by;
    logic        cin;
    logic [31:0] exp_op;
    logic        exp_c;
  } vec_t;

  vec_t        vecs[17];
  logic [32:0] sb[$];
  logic [32:0] exp_word;
  logic [31:0] cur_exp_op;
  logic        cur_exp_c;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Inputs are set just after a posedge; handshakes are sampled at the following negedge.
  task automatic tick();
    @(negedge clk);
    if (in_valid && in_ready && !flush && !reset) sb.push_back({cur_exp_c, cur_exp_op});
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", {shifter_carry, shifter_operand}, 33'h1_FFFF_FFFF ^ {shifter_carry, shifter_operand});
      end else begin
        exp_word = sb.pop_front();
        chk("scoreboard", {shifter_carry, shifter_operand}, exp_word);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    optype = v.op; rm_val = v.rm; bypass_rm = v.byp; should_bypass_rm = v.sel;
    shiftcode = v.code; shiftby = v.by; carry_in = v.cin;
    cur_exp_op = v.exp_op; cur_exp_c = v.exp_c;
    in_valid = 1'b1;
  endtask

  function automatic vec_t imm(input logic [31:0] val, input logic cin);
    vec_t v;
    v = '{OP_LDIMM, 32'hA5A5A5A5, val, 1'b1, 2'd1, 8'd7, cin, val, cin};
    return v;
  endfunction

  task automatic drain(input int budget);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    chk("drain_empty", 33'(sb.size()), 33'd0);
  endtask

  task automatic fill_out_and_skid(input logic [31:0] a, input logic [31:0] b);
    out_ready = 1'b0;
    drive(imm(a, 1'b1)); tick();
    drive(imm(b, 1'b1)); tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 33'(out_valid), 33'd0);
    chk({tag, "_operand"}, 33'(shifter_operand), 33'd0);
    chk({tag, "_carry"}, 33'(shifter_carry), 33'd0);
    chk({tag, "_in_ready"}, 33'(in_ready), 33'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{OP_ROR,   32'h0,        32'h000000FF, 1'b1, 2'd0, 8'd4,   1'b0, 32'hFF000000, 1'b1};
    vecs[1]  = '{OP_ROR,   32'h0,        32'h000000FF, 1'b1, 2'd0, 8'd0,   1'b1, 32'h000000FF, 1'b1};
    vecs[2]  = '{OP_SHIFT, 32'h80000001, 32'h0,        1'b0, 2'd1, 8'd0,   1'b0, 32'h00000000, 1'b1};
    vecs[3]  = '{OP_SHIFT, 32'h80000001, 32'h0,        1'b0, 2'd2, 8'd0,   1'b0, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{OP_SHIFT, 32'h80000001, 32'h0,        1'b0, 2'd3, 8'd0,   1'b0, 32'h40000000, 1'b1};
    vecs[5]  = '{OP_SHIFT, 32'h80000001, 32'h0,        1'b0, 2'd0, 8'd1,   1'b0, 32'h00000002, 1'b1};
    vecs[6]  = '{OP_SHIFT, 32'h12345678, 32'h0,        1'b0, 2'd0, 8'd0,   1'b0, 32'h12345678, 1'b0};
    vecs[7]  = '{OP_SHIFT, 32'h12345678, 32'h0,        1'b0, 2'd1, 8'd4,   1'b0, 32'h01234567, 1'b1};
    vecs[8]  = '{OP_SHIFT, 32'h80F00000, 32'h0,        1'b0, 2'd2, 8'd8,   1'b1, 32'hFF80F000, 1'b0};
    vecs[9]  = '{OP_SHIFT, 32'h0000000F, 32'h0,        1'b0, 2'd3, 8'd4,   1'b0, 32'hF0000000, 1'b1};
    vecs[10] = '{OP_LDREG, 32'h00000003, 32'h0,        1'b0, 2'd0, 8'hFF,  1'b0, 32'h80000000, 1'b1};
    vecs[11] = '{OP_LDIMM, 32'h0,        32'hDEADBEEF, 1'b1, 2'd1, 8'd5,   1'b1, 32'hDEADBEEF, 1'b1};
    vecs[12] = '{OP_OTHER, 32'hCAFEF00D, 32'h0,        1'b0, 2'd2, 8'd3,   1'b0, 32'hCAFEF00D, 1'b0};
    vecs[13] = '{OP_ROR,   32'h0,        32'h00000001, 1'b1, 2'd0, 8'h2F,  1'b1, 32'h00000004, 1'b0};
    vecs[14] = '{OP_SHIFT, 32'h7FFFFFFF, 32'h0,        1'b0, 2'd1, 8'h20,  1'b1, 32'h00000000, 1'b0};
    vecs[15] = '{OP_SHIFT, 32'h80000000, 32'h0,        1'b0, 2'd2, 8'd31,  1'b0, 32'hFFFFFFFF, 1'b0};
    vecs[16] = '{OP_SHIFT, 32'hFFFFFFFF, 32'h0000000F, 1'b1, 2'd0, 8'd4,   1'b1, 32'h000000F0, 1'b0};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_state("reset");

    // Back-to-back vectors with the consumer always ready
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      drive(vecs[i]);
      tick();
    end
    drain(10);
    chk("idle_out_valid", 33'(out_valid), 33'd0);

    // Backpressure: A fills the output, B lands in the skid
    fill_out_and_skid(32'h11, 32'h22);
    chk("bp_in_ready_low", 33'(in_ready), 33'd0);
    chk("bp_hold_valid", 33'(out_valid), 33'd1);
    tick(); tick();
    chk("bp_hold_operand", 33'(shifter_operand), 33'h11);
    out_ready = 1'b1;
    tick();
    chk("bp_second_next_cycle", {32'(out_valid), shifter_operand}, {32'd1, 32'h22});
    chk("bp_in_ready_back", 33'(in_ready), 33'd1);
    tick();
    chk("bp_done_valid", 33'(out_valid), 33'd0);
    chk("bp_sb_empty", 33'(sb.size()), 33'd0);

    // Flush with output and skid full and a new beat offered in the same cycle
    fill_out_and_skid(32'h33, 32'h44);
    drive(imm(32'h55, 1'b0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", 33'(out_valid), 33'd0);
    chk("flush_in_ready", 33'(in_ready), 33'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("flush_no_emit", 33'(out_valid), 33'd0);
    end

    // Reset while stalled with skid full
    fill_out_and_skid(32'h66, 32'h77);
    chk("pre_reset_skid_full", 33'(in_ready), 33'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    tick();
    chk_reset_state("stall_reset");

    // Flow resumes normally after the mid-stall reset
    out_ready = 1'b1;
    drive(vecs[0]);
    tick();
    drain(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/shift_exec_stage.md
Name: shift_exec_stage

Overview:
- Execute-side barrel shifter that consumes the shifter decoder's fields: rm index (resolved to a value by regfile read), bypass value, bypass select, shift code and shift amount.
- Produces the ARM shifter_operand and shifter_carry_out for the ALU.
- Registered stage (1-cycle latency) with valid/ready handshake, a one-entry skid buffer and pipeline flush, so ALU stalls never drop an operand.

Parameters:
DATAW, 32, operand/result width (equals FULLW)
AMTW, 8, width of shiftby input (equals WIDTH); only bits [4:0] are significant
OPW, OP_TYPE_W, width of optype input

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous squash of all held and incoming operands
in_valid  input  1  upstream fields valid
in_ready  output  1  stage can accept this cycle
optype  input  OPW  decoded op type (OP_DATA_SHIFT, OP_DATA_ROR, OP_LDSTR_IMM, OP_LDSTR_REG, other)
rm_val  input  DATAW  register-file value of rm
bypass_rm  input  DATAW  immediate operand from decoder
should_bypass_rm  input  1  1 selects bypass_rm, 0 selects rm_val
shiftcode  input  2  LSL=0, LSR=1, ASR=2, ROR=3
shiftby  input  AMTW  shift/rotate amount
carry_in  input  1  current CPSR C flag
out_valid  output  1  result valid
out_ready  input  1  ALU accepts result
shifter_operand  output  DATAW  shifted value
shifter_carry  output  1  shifter carry-out

Behaviour:
- Reset: out_valid=0, shifter_operand=0, shifter_carry=0, skid empty, so in_ready=1 the cycle after reset deasserts. Reset mid-transfer discards all contents.
- Operand: op = should_bypass_rm ? bypass_rm : rm_val. Amount: n = shiftby[4:0]. Bits [AMTW-1:5] are ignored.
- OP_DATA_ROR, immediate rotate: r = 2*shiftby[3:0] (0..30). Result = op rotated right by r.
  - Carry = carry_in if r==0, else result[31].
- OP_DATA_SHIFT and OP_LDSTR_REG, by shiftcode:
  - LSL: n==0 gives result=op, carry=carry_in. Otherwise result=op<<n, carry=op[32-n].
  - LSR: n==0 means shift by 32: result=0, carry=op[31]. Otherwise result=op>>n, carry=op[n-1].
  - ASR: n==0 means shift by 32: result = all bits op[31], carry=op[31]. Otherwise arithmetic shift, carry=op[n-1].
  - ROR: n==0 means RRX: result={carry_in, op[31:1]}, carry=op[0]. Otherwise rotate right by n, carry=op[n-1].
- OP_LDSTR_IMM and all other optypes: result=op, carry=carry_in, with shiftcode/shiftby ignored.
- Handshake:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
  - in_ready = ~skid_valid, a register-only function with no combinational path from out_ready.
- Latency: an accepted input appears on the outputs the next cycle if the output register is empty or drains that cycle.
- Stall: if the output register is full and not draining, an accepted input is computed and stored in the skid. in_ready drops the next cycle.
- Skid drain: when the output drains and the skid is full, the skid moves to the output and in_ready returns to 1 the next cycle.
- Ordering is strictly FIFO. Outputs are held stable while out_valid & ~out_ready.
- Flush: next cycle out_valid=0 and skid empty. An input accepted in the flush cycle is dropped. Flush has priority over all transfers. Data registers may hold stale values, but out_valid is 0.
- carry_in is sampled with the input fields at acceptance, not at output.

Test Plan:
- Reset then idle: after reset release -> out_valid=0, shifter_operand=0, shifter_carry=0, in_ready=1.
- OP_DATA_ROR, bypass_rm=0x000000FF, shiftby=4 (r=8), carry_in=0 -> one cycle later shifter_operand=0xFF000000, carry=1. Same with shiftby=0, carry_in=1 -> 0x000000FF, carry=1.
- OP_DATA_SHIFT, rm_val=0x80000001, successive beats with out_ready=1:
  - LSR n=0 -> 0x00000000, carry 1.
  - ASR n=0 -> 0xFFFFFFFF, carry 1.
  - ROR n=0 with carry_in=0 -> 0x40000000, carry 1.
  - LSL n=1 -> 0x00000002, carry 1.
- Backpressure: hold out_ready=0, send A=0x11 then B=0x22 (OP_LDSTR_IMM) -> in_ready=0 after B. Raise out_ready -> A then B emitted in consecutive cycles, none lost or duplicated, in_ready returns to 1.
- Flush with output and skid full, plus in_valid high in the flush cycle -> next cycle out_valid=0, in_ready=1, no later emission of any of the three operands.
- Reset asserted while stalled with skid full -> identical to the reset-state values above.
